sar_search: RTL and testbench
=============================

SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter N, default 8: width of the search value, trial and result.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-004 start  input  1  request to begin a search; sampled only in IDLE.
REQ-005 trial  output  N  candidate value, driven to the a input of an external comparator whose b input holds the target.
REQ-006 cmp_ls  input  1  external comparator result: trial < target.
REQ-007 cmp_gr  input  1  external comparator result: trial > target.
REQ-008 cmp_eq  input  1  external comparator result: trial == target.
REQ-009 busy  output  1  high while in SEARCH.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 result  output  N  search result; holds its value until the next accepted start.
REQ-012 found  output  1  high when cmp_eq was seen during the search; valid with done and held afterwards.
REQ-013 err  output  1  high when an invalid comparator code aborted the search; valid with done and held afterwards.

Function
REQ-014 The FSM SHALL have three states: IDLE, SEARCH and DONE.
REQ-015 In IDLE, start=1 SHALL move the FSM to SEARCH, clear found, err and result, set the bit index to N-1, and set trial to 1<<(N-1).
REQ-016 In SEARCH, cmp_ls, cmp_gr and cmp_eq SHALL be sampled every cycle against the trial value driven in that same cycle (the external comparator is combinational, zero latency).
REQ-017 In SEARCH, cmp_eq=1 SHALL set result to trial and found to 1, then move to DONE (early exit).
REQ-018 In SEARCH, cmp_gr=1 SHALL clear the bit under test.
REQ-019 In SEARCH, cmp_ls=1 SHALL keep the bit under test.
REQ-020 After REQ-018 or REQ-019, if the bit index > 0, the FSM SHALL decrement the index, set the next lower bit in trial, and stay in SEARCH.
REQ-021 After REQ-018 or REQ-019, if the bit index == 0, the FSM SHALL set result to the updated value (largest value <= target), leave found at 0, and move to DONE.
REQ-022 A comparator code other than one-hot (000, 011, 101, 110 or 111 on ls,gr,eq) during SEARCH SHALL set err to 1, result to 0 and found to 0, then move to DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 trial SHALL be 0 in IDLE and DONE; the comparator inputs SHALL be ignored outside SEARCH.
REQ-025 busy SHALL equal (state==SEARCH).
REQ-026 start SHALL be ignored in SEARCH and DONE; no queuing.
REQ-027 Latency: with start sampled at edge k, done SHALL be high in cycle k+1+m, where m is the number of SEARCH cycles, 1 <= m <= N.

Reset
REQ-028 rst=1 SHALL, at the next rising edge, force IDLE and set trial, result, found, err, done and busy to 0, regardless of state, including mid-search.
REQ-029 rst SHALL take priority over start in the same cycle; start is not accepted.

Verification (N=8, target on the comparator's b input, ideal comparator unless stated)
V-1 Target 0x80, start pulse -> trial 0x80; cmp_eq on the first SEARCH cycle; done 2 cycles after start; result=0x80, found=1.
V-2 Target 0x5A -> trial sequence 80,40,60,50,58,5C,5A; done after 7 SEARCH cycles; result=0x5A, found=1, err=0.
V-3 Target 0x00 -> trials 80,40,20,10,08,04,02,01, all cmp_gr; result=0x00, found=0, done after 8 SEARCH cycles.
V-4 Target 0xFF -> trials 80,C0,E0,F0,F8,FC,FE,FF; eq on the 8th; result=0xFF, found=1.
V-5 Force cmp code 000 on the 3rd SEARCH cycle -> next cycle done=1, err=1, result=0, found=0; a start asserted during SEARCH is ignored.
V-6 Assert rst on the 3rd SEARCH cycle with start=1 -> next cycle all outputs 0, FSM in IDLE, no search begun; a later start runs V-2 correctly.

Source files
------------

// File: rtl/sar_search.sv
// Successive-approximation search driving an external combinational comparator.
// One trial per cycle, MSB first, with early exit on equality.
module sar_search #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] trial,
  input  logic         cmp_ls,
  input  logic         cmp_gr,
  input  logic         cmp_eq,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         found,
  output logic         err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_trial;
  logic [N-1:0]   r_result;
  logic [IW-1:0]  r_idx;
  logic           r_found;
  logic           r_err;
  logic           r_done;

  logic [N-1:0]   w_bit;
  logic [N-1:0]   w_upd;
  logic [N-1:0]   w_nxt;
  logic [2:0]     w_code;

  // w_bit is the bit under test; w_nxt is the one tried next
  assign w_bit  = {{(N-1){1'b0}}, 1'b1} << r_idx;
  assign w_nxt  = w_bit >> 1;
  assign w_upd  = cmp_gr ? (r_trial & ~w_bit) : r_trial;
  assign w_code = {cmp_ls, cmp_gr, cmp_eq};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_trial  <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state  <= SEARCH;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_idx    <= IW'(N - 1);
            r_trial  <= {1'b1, {(N-1){1'b0}}};
          end
        end
        SEARCH: begin
          unique case (w_code)
            3'b001: begin
              r_result <= r_trial;
              r_found  <= 1'b1;
              r_trial  <= '0;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
            3'b010, 3'b100: begin
              if (r_idx != '0) begin
                r_trial <= w_upd | w_nxt;
                r_idx   <= r_idx - 1'b1;
              end else begin
                r_result <= w_upd;
                r_trial  <= '0;
                r_done   <= 1'b1;
                r_state  <= DONE;
              end
            end
            default: begin
              r_err    <= 1'b1;
              r_result <= '0;
              r_found  <= 1'b0;
              r_trial  <= '0;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          endcase
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign trial  = r_trial;
  assign busy   = (r_state == SEARCH);
  assign done   = r_done;
  assign result = r_result;
  assign found  = r_found;
  assign err    = r_err;

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search with a modelled comparator and
// optional invalid-code injection on a chosen SEARCH cycle.
module tb_sar_search;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] trial;
  logic         cmp_ls;
  logic         cmp_gr;
  logic         cmp_eq;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         found;
  logic         err;

  sar_search #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .trial  (trial),
    .cmp_ls (cmp_ls),
    .cmp_gr (cmp_gr),
    .cmp_eq (cmp_eq),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] res;
    logic         fnd;
    logic         er;
    int           m;
  } exp_t;

  exp_t         q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [N-1:0] target = '0;
  int           inj = 0;
  logic [2:0]   bad_code = 3'b000;
  int           sc = 0;
  bit           done_seen = 0;
  logic [N-1:0] h_res = '0;
  logic         h_fnd = 1'b0;
  logic         h_err = 1'b0;
  logic [2:0]   bads [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  // sc counts completed SEARCH cycles; it reaches k just before the
  // k-th SEARCH cycle's sampling edge, so injection lands on cycle k
  always_comb begin
    cmp_ls = (trial < target);
    cmp_gr = (trial > target);
    cmp_eq = (trial == target);
    if (busy && inj != 0 && sc == inj)
      {cmp_ls, cmp_gr, cmp_eq} = bad_code;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        done_seen = 1;
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("found", 32'(found), 32'(e.fnd));
          chk("err", 32'(err), 32'(e.er));
          chk("search_cycles", sc, e.m);
          h_res = e.res;
          h_fnd = e.fnd;
          h_err = e.er;
        end
        chk("trial_in_done", 32'(trial), 0);
        chk("busy_in_done", 32'(busy), 0);
      end else if (busy) begin
        chk("outs_cleared", 32'({result, found, err}), 0);
        if (sc == 0)
          chk("first_trial", 32'(trial), 32'(1 << (N - 1)));
      end else begin
        chk("trial_in_idle", 32'(trial), 0);
        chk("held", 32'({result, found, err}), 32'({h_res, h_fnd, h_err}));
      end
    end
    sc = busy ? sc + 1 : 0;
  end

  function automatic exp_t model(input logic [N-1:0] t, input int f);
    exp_t e;
    int m0;
    m0 = N;
    for (int j = N - 1; j >= 0; j--)
      if (t[j]) m0 = N - j;
    if (f != 0 && f <= m0) begin
      e.res = '0; e.fnd = 1'b0; e.er = 1'b1; e.m = f;
    end else begin
      e.res = t; e.fnd = (t != 0); e.er = 1'b0; e.m = m0;
    end
    return e;
  endfunction

  task automatic issue(input logic [N-1:0] t, input int f,
                       input logic [2:0] code);
    @(posedge clk); #1;
    target    = t;
    inj       = f;
    bad_code  = code;
    done_seen = 0;
    q.push_back(model(t, f));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input logic [N-1:0] t, input int f,
                     input logic [2:0] code, input bit poke);
    bit got;
    issue(t, f, code);
    if (poke) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 4 * N; i++) begin
      if (done_seen) begin
        got = 1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic reset_mid_search();
    issue(8'h5A, 0, 3'b000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst   = 1'b1;
    start = 1'b1;
    h_res = '0;
    h_fnd = 1'b0;
    h_err = 1'b0;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    void'(q.pop_back());
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_trial", 32'(trial), 0);
    chk("rst_outs", 32'({result, found, err}), 0);
    @(negedge clk);
    chk("rst_no_start", 32'(busy), 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] t;
    int f;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs",
        32'({trial, result, found, err, done, busy}), 0);
    rst = 1'b0;

    run(8'h80, 0, 3'b000, 0);
    run(8'h5A, 0, 3'b000, 0);
    run(8'h00, 0, 3'b000, 0);
    run(8'hFF, 0, 3'b000, 0);
    run(8'h5A, 3, 3'b000, 1);
    reset_mid_search();
    run(8'h5A, 0, 3'b000, 0);
    run(8'h01, 0, 3'b000, 1);
    run(8'hFE, N, 3'b111, 0);

    for (int i = 0; i < 60; i++) begin
      t = N'($urandom);
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N) : 0;
      run(t, f, bads[$urandom_range(0, 4)], bit'($urandom_range(0, 1)));
    end

    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
